// File: rtl/serial_xnor_frame_cmp.sv
// Serial bit-pair XNOR comparator: gathers FRAME_LEN equality results into a frame and
// hands out a verdict over valid/ready. Optional sticky error flag under XNOR_CMP_STICKY_EN.
module serial_xnor_frame_cmp #(
  parameter int FRAME_LEN = 8,
  parameter int ERR_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 a_bit,
  input  logic                 b_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_match,
  output logic [ERR_W-1:0]     out_err_cnt,
  output logic [FRAME_LEN-1:0] out_eq_bits
`ifdef XNOR_CMP_STICKY_EN
  ,
  input  logic                 sticky_clr,
  output logic                 err_sticky
`endif
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [ERR_W-1:0]     err_reg;
  logic [FRAME_LEN-1:0] vec_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic                 out_match_reg;
  logic [ERR_W-1:0]     out_err_cnt_reg;
  logic [FRAME_LEN-1:0] out_eq_bits_reg;

  logic                 eq;
  logic                 accept;
  logic                 last_beat;
  logic [ERR_W-1:0]     err_next;
  logic [FRAME_LEN-1:0] vec_next;

  assign eq        = ~(a_bit ^ b_bit);
  assign accept    = in_valid && in_ready_reg;
  assign last_beat = accept && (idx_reg == LAST_IDX);
  assign err_next  = err_reg + {{(ERR_W-1){1'b0}}, ~eq};

  // Working vector with the current beat merged in, so the final beat lands in the verdict.
  genvar gi;
  generate
    for (gi = 0; gi < FRAME_LEN; gi++) begin : g_vec
      assign vec_next[gi] = (idx_reg == IDX_W'(gi)) ? eq : vec_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= COLLECT;
      idx_reg         <= '0;
      err_reg         <= '0;
      vec_reg         <= '0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      out_match_reg   <= 1'b0;
      out_err_cnt_reg <= '0;
      out_eq_bits_reg <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            vec_reg <= vec_next;
            if (last_beat) begin
              state_reg       <= HOLD;
              in_ready_reg    <= 1'b0;
              out_valid_reg   <= 1'b1;
              out_eq_bits_reg <= vec_next;
              out_err_cnt_reg <= err_next;
              out_match_reg   <= (err_next == '0);
            end else begin
              idx_reg <= idx_reg + 1'b1;
              err_reg <= err_next;
            end
          end
        end
        HOLD: begin
          // Input beats are ignored here; only the output handshake moves us on.
          if (out_ready) begin
            state_reg     <= COLLECT;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            idx_reg       <= '0;
            err_reg       <= '0;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

`ifdef XNOR_CMP_STICKY_EN
  logic err_sticky_reg;

  // A mismatch verdict loading on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_reg <= 1'b0;
    end else if (last_beat && (err_next != '0)) begin
      err_sticky_reg <= 1'b1;
    end else if (sticky_clr) begin
      err_sticky_reg <= 1'b0;
    end
  end

  assign err_sticky = err_sticky_reg;
`endif

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_match   = out_match_reg;
  assign out_err_cnt = out_err_cnt_reg;
  assign out_eq_bits = out_eq_bits_reg;

endmodule

// File: tb/tb_serial_xnor_frame_cmp.sv
// Directed bench for serial_xnor_frame_cmp (FRAME_LEN=8); sticky checks only when
// XNOR_CMP_STICKY_EN is defined.
module tb_serial_xnor_frame_cmp;

  localparam int FRAME_LEN = 8;
  localparam int ERR_W     = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 a_bit = 1'b0;
  logic                 b_bit = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_match;
  logic [ERR_W-1:0]     out_err_cnt;
  logic [FRAME_LEN-1:0] out_eq_bits;
`ifdef XNOR_CMP_STICKY_EN
  logic                 sticky_clr = 1'b0;
  logic                 err_sticky;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_xnor_frame_cmp #(.FRAME_LEN(FRAME_LEN), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a_bit      (a_bit),
    .b_bit      (b_bit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_match  (out_match),
    .out_err_cnt(out_err_cnt),
    .out_eq_bits(out_eq_bits)
`ifdef XNOR_CMP_STICKY_EN
    ,
    .sticky_clr (sticky_clr),
    .err_sticky (err_sticky)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends bits [first .. first+count-1] of a/b, optionally with an idle cycle after each beat.
  task automatic send_beats(input logic [7:0] a, input logic [7:0] b,
                            input int first, input int count, input bit gap);
    for (int i = first; i < first + count; i++) begin
      in_valid = 1'b1;
      a_bit    = a[i];
      b_bit    = b[i];
      tick();
      in_valid = 1'b0;
      if (gap && (i != first + count - 1)) tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    tick(); tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_match !== 1'b0 ||
        out_err_cnt !== 4'd0 || out_eq_bits !== 8'h00) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_match=%b cnt=%0d eq=%h, required 1 0 0 0 00",
               in_ready, out_valid, out_match, out_err_cnt, out_eq_bits);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_equal();
    out_ready = 1'b1;
    send_beats(8'hA5, 8'hA5, 0, 7, 1'b0);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL equal_early_valid: out_valid=%b required 0", out_valid);
    end
    send_beats(8'hA5, 8'hA5, 7, 1, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_eq_bits !== 8'hFF || out_err_cnt !== 4'd0 || out_match !== 1'b1) begin
      fails++;
      $display("FAIL equal_verdict: valid=%b eq=%h cnt=%0d match=%b, required 1 ff 0 1",
               out_valid, out_eq_bits, out_err_cnt, out_match);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL equal_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_all_unequal();
    out_ready = 1'b1;
    send_beats(8'hA5, 8'h5A, 0, 8, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_eq_bits !== 8'h00 || out_err_cnt !== 4'd8 || out_match !== 1'b0) begin
      fails++;
      $display("FAIL unequal_verdict: valid=%b eq=%h cnt=%0d match=%b, required 1 00 8 0",
               out_valid, out_eq_bits, out_err_cnt, out_match);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL unequal_release: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beats(8'hF0, 8'hF1, 0, 8, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || out_eq_bits !== 8'hFE || out_err_cnt !== 4'd1 || out_match !== 1'b0) begin
      fails++;
      $display("FAIL bp_verdict: valid=%b eq=%h cnt=%0d match=%b, required 1 fe 1 0",
               out_valid, out_eq_bits, out_err_cnt, out_match);
    end
    in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_eq_bits !== 8'hFE || out_err_cnt !== 4'd1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b eq=%h cnt=%0d, required 1 0 fe 1",
                 c, out_valid, in_ready, out_eq_bits, out_err_cnt);
      end
    end
    // Handshake with in_valid still high: that beat must not be taken.
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send_beats(8'h3C, 8'h3C, 0, 7, 1'b0);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_stray_beat: out_valid=%b after 7 beats, required 0", out_valid);
    end
    send_beats(8'h3C, 8'h3C, 7, 1, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_eq_bits !== 8'hFF || out_err_cnt !== 4'd0 || out_match !== 1'b1) begin
      fails++;
      $display("FAIL bp_next_frame: valid=%b eq=%h cnt=%0d match=%b, required 1 ff 0 1",
               out_valid, out_eq_bits, out_err_cnt, out_match);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    send_beats(8'h00, 8'hFF, 0, 4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_state: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send_beats(8'h00, 8'h00, 0, 7, 1'b0);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_early: out_valid=%b after 7 beats, required 0", out_valid);
    end
    send_beats(8'h00, 8'h00, 7, 1, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_err_cnt !== 4'd0 || out_match !== 1'b1 || out_eq_bits !== 8'hFF) begin
      fails++;
      $display("FAIL midrst_verdict: valid=%b cnt=%0d match=%b eq=%h, required 1 0 1 ff",
               out_valid, out_err_cnt, out_match, out_eq_bits);
    end
    tick();
  endtask

  task automatic test_reset_in_hold();
    out_ready = 1'b0;
    send_beats(8'h12, 8'h34, 0, 8, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_eq_bits !== 8'hD9 || out_err_cnt !== 4'd3) begin
      fails++;
      $display("FAIL holdrst_verdict: valid=%b eq=%h cnt=%0d, required 1 d9 3",
               out_valid, out_eq_bits, out_err_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL holdrst_drop: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
  endtask

`ifdef XNOR_CMP_STICKY_EN
  task automatic test_sticky();
    out_ready = 1'b1;
    tests++;
    if (err_sticky !== 1'b0) begin
      fails++; $display("FAIL sticky_init: err_sticky=%b required 0", err_sticky);
    end
    send_beats(8'hA5, 8'h5A, 0, 8, 1'b0);
    tests++;
    if (err_sticky !== 1'b1) begin
      fails++; $display("FAIL sticky_set: err_sticky=%b required 1", err_sticky);
    end
    tick();
    send_beats(8'h3C, 8'h3C, 0, 8, 1'b0);
    tests++;
    if (err_sticky !== 1'b1) begin
      fails++; $display("FAIL sticky_keep: err_sticky=%b required 1", err_sticky);
    end
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests++;
    if (err_sticky !== 1'b0) begin
      fails++; $display("FAIL sticky_clear: err_sticky=%b required 0", err_sticky);
    end
    // Mismatch verdict and clear on the same edge: set has priority.
    send_beats(8'hFF, 8'h7F, 0, 7, 1'b0);
    sticky_clr = 1'b1;
    send_beats(8'hFF, 8'h7F, 7, 1, 1'b0);
    sticky_clr = 1'b0;
    tests++;
    if (err_sticky !== 1'b1 || out_err_cnt !== 4'd1) begin
      fails++; $display("FAIL sticky_set_wins: err_sticky=%b cnt=%0d required 1 1", err_sticky, out_err_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_equal();
    test_all_unequal();
    test_backpressure();
    test_reset_mid_frame();
    test_reset_in_hold();
`ifdef XNOR_CMP_STICKY_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
